// File: rtl/data_ram_sp.sv
// Single-port 256 x 32 synchronous data memory for the MEM stage.
// One-cycle registered read, write-first on a same-address read-during-write.
module data_ram_sp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Power-up value of every word: zero for a deterministic boot image,
    // otherwise left undefined so the tools may map to uninitialised RAM.
    localparam logic [DATA_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? '0 : 'x;

    // NOTE: the array has no reset branch; resetting it would turn the RAM
    // into thousands of flops, and the CPU relies on contents surviving reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};
    logic [DATA_W-1:0] q_reg = '0;

    logic write_en;

    assign write_en = wren && !reset;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[address] <= data;
        end
    end

    // Write-first: the word being written bypasses the array into q_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg <= '0;
        end else if (wren) begin
            q_reg <= data;
        end else begin
            q_reg <= mem[address];
        end
    end

    assign q = q_reg;

endmodule

// File: tb/tb_data_ram_sp.sv
// Directed-vector bench for data_ram_sp: reset, write/read, read-during-write,
// address boundaries, reset retention and a full-depth burst.
module tb_data_ram_sp;

    logic        clk;
    logic        reset;
    logic [7:0]  address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;

    int vectors;
    int miscompares;

    data_ram_sp #(
        .DATA_W   (32),
        .ADDR_W   (8),
        .INIT_ZERO(1)
    ) dut (
        .clock  (clk),
        .reset  (reset),
        .address(address),
        .data   (data),
        .wren   (wren),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        reset   = r;
        wren    = w;
        address = a;
        data    = d;
    endtask

    task automatic test_reset();
        // q must already be 0 before any edge.
        #1;
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL power_up_q got %h want %h", q, 32'h0);
        end
        drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (q !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_q_edge%0d got %h want %h", i, q, 32'h0);
            end
        end
        drive(1'b0, 1'b0, 8'h10, 32'h0);
        step();
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_write_suppressed got %h want %h", q, 32'h0);
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 8'h05, 32'h12345678);
        step();
        drive(1'b0, 1'b0, 8'h06, 32'h0);
        step();
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_rd_neighbour got %h want %h", q, 32'h0);
        end
        drive(1'b0, 1'b0, 8'h05, 32'h0);
        step();
        vectors++;
        if (q !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_rd_0x05 got %h want %h", q, 32'h12345678);
        end
        // Holds until the next edge.
        #3;
        vectors++;
        if (q !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_rd_hold got %h want %h", q, 32'h12345678);
        end
    endtask

    task automatic test_read_during_write();
        drive(1'b0, 1'b1, 8'h20, 32'hA5A5A5A5);
        step();
        vectors++;
        if (q !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL rdw_same_edge got %h want %h", q, 32'hA5A5A5A5);
        end
        drive(1'b0, 1'b1, 8'h20, 32'h5A5A5A5A);
        step();
        vectors++;
        if (q !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL rdw_overwrite got %h want %h", q, 32'h5A5A5A5A);
        end
        drive(1'b0, 1'b0, 8'h20, 32'h0);
        step();
        vectors++;
        if (q !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL rdw_readback got %h want %h", q, 32'h5A5A5A5A);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0]  addrs [4] = '{8'h00, 8'hFF, 8'h01, 8'hFE};
        logic [31:0] exps  [4] = '{32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0};
        drive(1'b0, 1'b1, 8'h00, 32'h00000001);
        step();
        drive(1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, addrs[i], 32'h0);
            step();
            vectors++;
            if (q !== exps[i]) begin
                miscompares++;
                $display("FAIL boundary_%h got %h want %h", addrs[i], q, exps[i]);
            end
        end
    endtask

    task automatic test_reset_retention();
        drive(1'b0, 1'b1, 8'h33, 32'hCAFEF00D);
        step();
        // Write attempted on the reset edge must be dropped.
        drive(1'b1, 1'b1, 8'h33, 32'h11111111);
        step();
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL retention_reset_q got %h want %h", q, 32'h0);
        end
        drive(1'b0, 1'b0, 8'h33, 32'h0);
        step();
        vectors++;
        if (q !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL retention_readback got %h want %h", q, 32'hCAFEF00D);
        end
        // Reset mid-read discards the pending read.
        drive(1'b1, 1'b0, 8'h33, 32'h0);
        step();
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL retention_read_discard got %h want %h", q, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 8'(i), 32'(i * 3));
            step();
            vectors++;
            if (q !== 32'(i * 3)) begin
                miscompares++;
                $display("FAIL burst_wr_%0d got %h want %h", i, q, 32'(i * 3));
            end
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b0, 8'(i), 32'h0);
            exp = 32'(i * 3);
            step();
            vectors++;
            if (q !== exp) begin
                miscompares++;
                $display("FAIL burst_rd_%0d got %h want %h", i, q, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        test_reset();
        test_write_read();
        test_read_during_write();
        test_boundaries();
        test_reset_retention();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
